// File: rtl/clock_pkg.sv
// Shared definitions for the alarm scheduler: slot count, time field widths,
// the scheduler FSM state type and the alarm/clock time comparison helper.
package clock_pkg;

  localparam int NUM_ALARM_SLOTS = 4;
  localparam int SLOT_W          = 2;
  localparam int HOUR_W          = 5;
  localparam int MIN_W           = 6;
  localparam int SEC_W           = 6;
  localparam int CNT_W           = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RING = 1'b1
  } alarm_state_t;

  // Hours and minutes must agree; the AM/PM flag only matters in 12-hour mode.
  function automatic logic time_match(
    input logic [HOUR_W-1:0] a_hh,
    input logic [MIN_W-1:0]  a_mm,
    input logic              a_ap,
    input logic [HOUR_W-1:0] b_hh,
    input logic [MIN_W-1:0]  b_mm,
    input logic              b_ap,
    input logic              twelve_24
  );
    return (a_hh == b_hh) && (a_mm == b_mm) && (!twelve_24 || (a_ap == b_ap));
  endfunction

endpackage

// File: rtl/snooze_time_add.sv
// Combinational wall-clock adder: hh:mm (+ am_pm) plus ADD_MIN minutes,
// wrapping the hour in either 12-hour or 24-hour mode. Only built when the
// snooze feature (ALARM_SNOOZE_EN) is compiled in, since nothing else uses it.
`ifdef ALARM_SNOOZE_EN
module snooze_time_add
  import clock_pkg::*;
#(
  parameter int ADD_MIN = 5
) (
  input  logic              twelve_24,
  input  logic [HOUR_W-1:0] hh,
  input  logic [MIN_W-1:0]  mm,
  input  logic              am_pm,
  output logic [HOUR_W-1:0] sum_hh,
  output logic [MIN_W-1:0]  sum_mm,
  output logic              sum_am_pm
);

  logic [MIN_W:0] mm_sum;

  // Add the minutes, then carry one hour when the minute field overflows.
  // 12-hour mode: 11 -> 12 flips AM/PM, 12 -> 1 keeps it.
  always_comb begin
    mm_sum    = {1'b0, mm} + 7'(ADD_MIN);
    sum_hh    = hh;
    sum_mm    = mm_sum[MIN_W-1:0];
    sum_am_pm = am_pm;
    if (mm_sum >= 7'd60) begin
      sum_mm = 6'(mm_sum - 7'd60);
      if (twelve_24) begin
        if (hh == 5'd11) begin
          sum_hh    = 5'd12;
          sum_am_pm = ~am_pm;
        end else if (hh == 5'd12) begin
          sum_hh = 5'd1;
        end else begin
          sum_hh = hh + 5'd1;
        end
      end else begin
        if (hh == 5'd23) sum_hh = '0;
        else             sum_hh = hh + 5'd1;
      end
    end
  end

endmodule
`endif

// File: rtl/alarm_scheduler.sv
// Four-slot alarm scheduler. Slots are compared against the running clock at
// the top of each minute; matching slots become pending and are rung one at a
// time, lowest index first, for RING_SECS ticks or until dismissed, snoozed or
// rewritten. Optional snooze support is built when ALARM_SNOOZE_EN is defined;
// without it the snooze input is ignored and no snooze targets exist.
module alarm_scheduler
  import clock_pkg::*;
#(
  parameter int RING_SECS  = 10,
  parameter int SNOOZE_MIN = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic [HOUR_W-1:0]          hh,
  input  logic [MIN_W-1:0]           mm,
  input  logic [SEC_W-1:0]           ss,
  input  logic                       am_pm,
  input  logic                       twelve_24,
  input  logic                       wr_en,
  input  logic [SLOT_W-1:0]          wr_slot,
  input  logic [HOUR_W-1:0]          wr_hh,
  input  logic [MIN_W-1:0]           wr_mm,
  input  logic                       wr_am_pm,
  input  logic                       wr_on,
  input  logic                       snooze,
  input  logic                       dismiss,
  output logic                       alarm_signal,
  output logic [SLOT_W-1:0]          active_slot,
  output logic [NUM_ALARM_SLOTS-1:0] pending,
  output logic [NUM_ALARM_SLOTS-1:0] slot_on
);

  // Current FSM state, kept as a named signal so checkers can bind to it.
  alarm_state_t state;

  logic [HOUR_W-1:0] slot_hh [NUM_ALARM_SLOTS];
  logic [MIN_W-1:0]  slot_mm [NUM_ALARM_SLOTS];
  logic              slot_ap [NUM_ALARM_SLOTS];
  logic [CNT_W-1:0]  ring_cnt;

  logic                       second_zero;
  logic [NUM_ALARM_SLOTS-1:0] alarm_hit;
  logic [NUM_ALARM_SLOTS-1:0] snz_hit;
  logic [NUM_ALARM_SLOTS-1:0] wr_mask;
  logic [NUM_ALARM_SLOTS-1:0] ring_clear;
  logic [NUM_ALARM_SLOTS-1:0] grant_avail;
  logic                       grant_any;
  logic [SLOT_W-1:0]          grant_slot;
  logic                       ring_write_hit;
  logic                       ring_dismiss;
  logic                       ring_snooze;
  logic                       ring_timeout;
  logic                       ring_exit;

  assign second_zero = tick && (ss == '0);
  assign wr_mask     = wr_en ? (NUM_ALARM_SLOTS'(1) << wr_slot) : '0;

  // Exit reasons while ringing, in priority order: rewrite of the ringing
  // slot, dismiss, snooze, then expiry of the ring time.
  assign ring_write_hit = (state == RING) && wr_en && (wr_slot == active_slot);
  assign ring_dismiss   = (state == RING) && !ring_write_hit && dismiss;
  assign ring_timeout   = (state == RING) && !ring_write_hit && !dismiss && !ring_snooze &&
                          tick && (ring_cnt == CNT_W'(RING_SECS - 1));
  assign ring_exit      = ring_write_hit || ring_dismiss || ring_snooze || ring_timeout;
  assign ring_clear     = ring_exit ? (NUM_ALARM_SLOTS'(1) << active_slot) : '0;

  // A slot being rewritten this cycle is not eligible for a grant.
  assign grant_avail = pending & ~wr_mask;

  // Top-of-minute comparison of every enabled slot against the clock.
  always_comb begin
    alarm_hit = '0;
    for (int i = 0; i < NUM_ALARM_SLOTS; i++) begin
      alarm_hit[i] = second_zero && slot_on[i] &&
                     time_match(slot_hh[i], slot_mm[i], slot_ap[i], hh, mm, am_pm, twelve_24);
    end
  end

  // Lowest-index pending slot wins the grant.
  always_comb begin
    grant_any  = 1'b0;
    grant_slot = '0;
    for (int i = NUM_ALARM_SLOTS - 1; i >= 0; i--) begin
      if (grant_avail[i]) begin
        grant_any  = 1'b1;
        grant_slot = SLOT_W'(i);
      end
    end
  end

`ifdef ALARM_SNOOZE_EN
  logic [HOUR_W-1:0]          snz_hh [NUM_ALARM_SLOTS];
  logic [MIN_W-1:0]           snz_mm [NUM_ALARM_SLOTS];
  logic                       snz_ap [NUM_ALARM_SLOTS];
  logic [NUM_ALARM_SLOTS-1:0] snz_valid;
  logic [HOUR_W-1:0]          sum_hh;
  logic [MIN_W-1:0]           sum_mm;
  logic                       sum_am_pm;

  assign ring_snooze = (state == RING) && !ring_write_hit && !dismiss && snooze;

  snooze_time_add #(
    .ADD_MIN (SNOOZE_MIN)
  ) u_snooze_add (
    .twelve_24 (twelve_24),
    .hh        (hh),
    .mm        (mm),
    .am_pm     (am_pm),
    .sum_hh    (sum_hh),
    .sum_mm    (sum_mm),
    .sum_am_pm (sum_am_pm)
  );

  // Snooze targets match by the same rule as the slot alarms.
  always_comb begin
    snz_hit = '0;
    for (int i = 0; i < NUM_ALARM_SLOTS; i++) begin
      snz_hit[i] = second_zero && snz_valid[i] &&
                   time_match(snz_hh[i], snz_mm[i], snz_ap[i], hh, mm, am_pm, twelve_24);
    end
  end

  // Snooze target per slot: a rewrite or dismiss kills it, a snooze of the
  // ringing slot (re)arms it from the current time, and a match consumes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ALARM_SLOTS; i++) begin
        snz_hh[i] <= '0;
        snz_mm[i] <= '0;
        snz_ap[i] <= 1'b0;
      end
      snz_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_ALARM_SLOTS; i++) begin
        if (wr_mask[i] || (ring_dismiss && (active_slot == SLOT_W'(i)))) begin
          snz_valid[i] <= 1'b0;
        end else if (ring_snooze && (active_slot == SLOT_W'(i))) begin
          snz_hh[i]    <= sum_hh;
          snz_mm[i]    <= sum_mm;
          snz_ap[i]    <= sum_am_pm;
          snz_valid[i] <= 1'b1;
        end else if (snz_hit[i]) begin
          snz_valid[i] <= 1'b0;
        end
      end
    end
  end
`else
  localparam int unused_snooze_min = SNOOZE_MIN;
  logic unused_snooze;

  assign unused_snooze = snooze;
  assign ring_snooze   = 1'b0;
  assign snz_hit       = '0;
`endif

  // Slot program storage and pending bits; a write always beats a match.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ALARM_SLOTS; i++) begin
        slot_hh[i] <= '0;
        slot_mm[i] <= '0;
        slot_ap[i] <= 1'b0;
      end
      slot_on <= '0;
      pending <= '0;
    end else begin
      pending <= ((pending & ~ring_clear) | alarm_hit | snz_hit) & ~wr_mask;
      if (wr_en) begin
        slot_hh[wr_slot] <= wr_hh;
        slot_mm[wr_slot] <= wr_mm;
        slot_ap[wr_slot] <= wr_am_pm;
        slot_on[wr_slot] <= wr_on;
      end
    end
  end

  // Ring sequencer: grant in IDLE, count ticks and watch exit reasons in RING.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      active_slot  <= '0;
      ring_cnt     <= '0;
      alarm_signal <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            state        <= RING;
            active_slot  <= grant_slot;
            ring_cnt     <= '0;
            alarm_signal <= 1'b1;
          end
        end
        RING: begin
          if (ring_exit) begin
            state        <= IDLE;
            alarm_signal <= 1'b0;
          end else if (tick) begin
            ring_cnt <= ring_cnt + CNT_W'(1);
          end
        end
        default: begin
          state        <= IDLE;
          alarm_signal <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_scheduler.sv
// Self-checking bench for alarm_scheduler. A reference model works in
// minutes-of-day and per-slot flags, predicts the outputs after every clock
// edge and queues them; a compare process checks each prediction on the
// following falling edge. Directed scenarios add literal expectations, and
// randomized phases exercise overlapping alarms, writes, snooze and dismiss.
// Build with ALARM_SNOOZE_EN defined to exercise the snooze feature.
module tb_alarm_scheduler;

  localparam int RING_SECS  = 10;
  localparam int SNOOZE_MIN = 5;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ = 1'b1;
`else
  localparam bit SNZ = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst, tick, am_pm, twelve_24;
  logic [4:0] hh;
  logic [5:0] mm, ss;
  logic       wr_en, wr_am_pm, wr_on, snooze, dismiss;
  logic [1:0] wr_slot;
  logic [4:0] wr_hh;
  logic [5:0] wr_mm;
  logic       alarm_signal;
  logic [1:0] active_slot;
  logic [3:0] pending, slot_on;

  always #5 clk = ~clk;

  alarm_scheduler #(.RING_SECS(RING_SECS), .SNOOZE_MIN(SNOOZE_MIN)) dut (
    .clk(clk), .rst(rst), .tick(tick), .hh(hh), .mm(mm), .ss(ss), .am_pm(am_pm),
    .twelve_24(twelve_24), .wr_en(wr_en), .wr_slot(wr_slot), .wr_hh(wr_hh),
    .wr_mm(wr_mm), .wr_am_pm(wr_am_pm), .wr_on(wr_on), .snooze(snooze),
    .dismiss(dismiss), .alarm_signal(alarm_signal), .active_slot(active_slot),
    .pending(pending), .slot_on(slot_on)
  );

  int n_total = 0;
  int n_bad   = 0;
  int tod     = 0;   // bench wall clock, seconds of day (24h)

  // ---------------- reference model ----------------
  int       m_hh [4];
  int       m_mm [4];
  bit       m_ap [4];
  bit [3:0] m_on;
  int       t_hh [4];
  int       t_mm [4];
  bit       t_ap [4];
  bit       t_valid [4];
  bit [3:0] m_pend;
  bit       m_ring;
  int       m_slot, m_cnt;
  logic [10:0] exp_q[$];

  function automatic bit same_time(int h, int m, bit a);
    return (h == int'(hh)) && (m == int'(mm)) && (!twelve_24 || (a == am_pm));
  endfunction

  always @(posedge clk) begin : ref_model
    bit       hit_a [4];
    bit       hit_t [4];
    bit [3:0] old_pend, wr_m;
    bit       leave;
    int       h24, tot;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_hh[i] = 0; m_mm[i] = 0; m_ap[i] = 0;
        t_hh[i] = 0; t_mm[i] = 0; t_ap[i] = 0; t_valid[i] = 0;
      end
      m_on = 0; m_pend = 0; m_ring = 0; m_slot = 0; m_cnt = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        hit_a[i] = tick && (ss == 0) && m_on[i] && same_time(m_hh[i], m_mm[i], m_ap[i]);
        hit_t[i] = SNZ && tick && (ss == 0) && t_valid[i] && same_time(t_hh[i], t_mm[i], t_ap[i]);
        if (hit_t[i]) t_valid[i] = 0;
      end
      old_pend = m_pend;
      wr_m = 0;
      if (wr_en) wr_m[wr_slot] = 1'b1;
      leave = 0;
      if (m_ring) begin
        if (wr_en && (int'(wr_slot) == m_slot)) begin
          leave = 1;
        end else if (dismiss) begin
          leave = 1;
          t_valid[m_slot] = 0;
        end else if (SNZ && snooze) begin
          leave = 1;
          h24 = twelve_24 ? (int'(hh) % 12) + (am_pm ? 12 : 0) : int'(hh);
          tot = (h24 * 60 + int'(mm) + SNOOZE_MIN) % 1440;
          t_mm[m_slot] = tot % 60;
          if (twelve_24) begin
            t_ap[m_slot] = (tot / 60) >= 12;
            t_hh[m_slot] = ((tot / 60) % 12 == 0) ? 12 : (tot / 60) % 12;
          end else begin
            t_ap[m_slot] = am_pm;
            t_hh[m_slot] = tot / 60;
          end
          t_valid[m_slot] = 1;
        end else if (tick) begin
          m_cnt++;
          if (m_cnt == RING_SECS) leave = 1;
        end
      end
      if (leave) m_pend[m_slot] = 0;
      for (int i = 0; i < 4; i++) if (hit_a[i] || hit_t[i]) m_pend[i] = 1;
      if (m_ring) begin
        if (leave) m_ring = 0;
      end else begin
        for (int i = 3; i >= 0; i--) begin
          if (old_pend[i] && !wr_m[i]) begin
            m_ring = 1; m_slot = i; m_cnt = 0;
          end
        end
      end
      if (wr_en) begin
        m_hh[wr_slot] = wr_hh; m_mm[wr_slot] = wr_mm; m_ap[wr_slot] = wr_am_pm;
        m_on[wr_slot] = wr_on; m_pend[wr_slot] = 0; t_valid[wr_slot] = 0;
      end
    end
    exp_q.push_back({m_ring, 2'(m_slot), m_pend, m_on});
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin : compare
    logic [10:0] e, a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {alarm_signal, active_slot, pending, slot_on};
      n_total++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL outputs @%0t: got alarm=%b slot=%0d pend=%b on=%b, want alarm=%b slot=%0d pend=%b on=%b",
                 $time, a[10], a[9:8], a[7:4], a[3:0], e[10], e[9:8], e[7:4], e[3:0]);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tod_to_fields(input int t, output int h, output int m, output int s, output bit a);
    int h24;
    h24 = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    if (twelve_24) begin
      a = (h24 >= 12);
      h = (h24 % 12 == 0) ? 12 : h24 % 12;
    end else begin
      a = 0;
      h = h24;
    end
  endtask

  task automatic set_tod(input int t);
    int h, m, s;
    bit a;
    tod = t;
    tod_to_fields(t, h, m, s, a);
    hh = 5'(h); mm = 6'(m); ss = 6'(s); am_pm = a;
  endtask

  task automatic clear_ctrl();
    wr_en = 0; snooze = 0; dismiss = 0;
  endtask

  task automatic reset_dut();
    rst = 1; tick = 0; clear_ctrl();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic tick_next(input int adv);
    set_tod((tod + adv) % 86400);
    tick = 1;
    @(negedge clk);
    tick = 0;
  endtask

  task automatic run_secs(input int n);
    repeat (n) begin
      tick_next(1);
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic write_slot(input int s, input int h, input int m, input bit a, input bit on);
    wr_en = 1; wr_slot = 2'(s); wr_hh = 5'(h); wr_mm = 6'(m); wr_am_pm = a; wr_on = on;
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic rand_ctrl(input int base);
    int h, m, s;
    bit a;
    snooze  = ($urandom_range(0, 7) == 0);
    dismiss = ($urandom_range(0, 11) == 0);
    wr_en   = ($urandom_range(0, 29) == 0);
    if (wr_en) begin
      tod_to_fields(base + $urandom_range(0, 8) * 60, h, m, s, a);
      wr_slot = 2'($urandom_range(0, 3)); wr_hh = 5'(h); wr_mm = 6'(m);
      wr_am_pm = a; wr_on = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic random_phase(input bit m12, input int n_ticks);
    int base, h, m, s;
    bit a;
    reset_dut();
    twelve_24 = m12;
    base = $urandom_range(0, 23) * 3600 + $urandom_range(0, 50) * 60;
    for (int i = 0; i < 4; i++) begin
      tod_to_fields(base + $urandom_range(0, 8) * 60, h, m, s, a);
      write_slot(i, h, m, a, $urandom_range(0, 3) != 0);
    end
    set_tod((base + 86400 - 20) % 86400);
    repeat (n_ticks) begin
      rand_ctrl(base);
      if ($urandom_range(0, 9) == 0) tick_next(60 - tod % 60);
      else tick_next(1);
      clear_ctrl();
      repeat ($urandom_range(1, 3)) begin
        rand_ctrl(base);
        @(negedge clk);
        clear_ctrl();
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1; tick = 0; twelve_24 = 0; hh = 0; mm = 0; ss = 0; am_pm = 0;
    wr_slot = 0; wr_hh = 0; wr_mm = 0; wr_am_pm = 0; wr_on = 0;
    clear_ctrl();
    repeat (3) @(negedge clk);
    check("reset_alarm", alarm_signal, 0);
    check("reset_slot_on", slot_on, 0);
    check("reset_pending", pending, 0);
    rst = 0;

    // 12h: slot0 = 07:30 PM, clock 07:29:59 PM -> 07:30:00 PM
    reset_dut();
    twelve_24 = 1;
    write_slot(0, 7, 30, 1, 1);
    check("wr_slot_on", slot_on, 4'b0001);
    set_tod(19 * 3600 + 29 * 60 + 59);
    tick_next(1);
    check("pm_pending", pending, 4'b0001);
    check("pm_alarm_early", alarm_signal, 0);
    @(negedge clk);
    check("pm_alarm_on", alarm_signal, 1);
    check("pm_active", active_slot, 0);
    run_secs(RING_SECS - 1);
    check("pm_still_ringing", alarm_signal, 1);
    tick_next(1);
    check("pm_alarm_off", alarm_signal, 0);
    check("pm_pending_clr", pending, 0);

    // 24h: slots 1 and 2 at 06:00; slot 1 first, slot 2 after timeout
    reset_dut();
    twelve_24 = 0;
    write_slot(1, 6, 0, 0, 1);
    write_slot(2, 6, 0, 0, 1);
    set_tod(5 * 3600 + 59 * 60 + 59);
    tick_next(1);
    check("dual_pending", pending, 4'b0110);
    @(negedge clk);
    check("dual_first", active_slot, 1);
    run_secs(RING_SECS - 1);
    tick_next(1);
    check("dual_gap_alarm", alarm_signal, 0);
    check("dual_gap_pending", pending, 4'b0100);
    @(negedge clk);
    check("dual_second", active_slot, 2);
    check("dual_second_alarm", alarm_signal, 1);
    // rewriting the ringing slot silences it
    write_slot(2, 6, 0, 0, 0);
    check("wr_ring_alarm", alarm_signal, 0);
    check("wr_ring_pending", pending, 0);
    check("wr_ring_on", slot_on, 4'b0010);

    // reset while ringing
    reset_dut();
    write_slot(0, 8, 15, 0, 1);
    set_tod(8 * 3600 + 14 * 60 + 59);
    tick_next(1);
    @(negedge clk);
    check("rst_ring_pre", alarm_signal, 1);
    rst = 1; dismiss = 1; snooze = 1;
    @(negedge clk);
    check("rst_ring_alarm", alarm_signal, 0);
    check("rst_ring_pending", pending, 0);
    check("rst_ring_on", slot_on, 0);
    rst = 0; clear_ctrl();

`ifdef ALARM_SNOOZE_EN
    // 12h: slot3 = 11:58 AM, snooze -> 12:03 PM
    reset_dut();
    twelve_24 = 1;
    write_slot(3, 11, 58, 0, 1);
    set_tod(11 * 3600 + 57 * 60 + 59);
    tick_next(1);
    @(negedge clk);
    check("snz12_active", active_slot, 3);
    snooze = 1;
    @(negedge clk);
    snooze = 0;
    check("snz12_alarm_off", alarm_signal, 0);
    check("snz12_pending_clr", pending, 0);
    set_tod(12 * 3600 + 2 * 60 + 59);
    tick_next(1);
    check("snz12_rematch", pending, 4'b1000);
    @(negedge clk);
    check("snz12_rering", alarm_signal, 1);

    // 24h: slot0 = 23:57, snooze -> 00:02
    reset_dut();
    twelve_24 = 0;
    write_slot(0, 23, 57, 0, 1);
    set_tod(23 * 3600 + 56 * 60 + 59);
    tick_next(1);
    @(negedge clk);
    snooze = 1;
    @(negedge clk);
    snooze = 0;
    check("snz24_alarm_off", alarm_signal, 0);
    set_tod(1 * 60 + 59);
    tick_next(1);
    check("snz24_rematch", pending, 4'b0001);
    @(negedge clk);
    check("snz24_rering", alarm_signal, 1);

    // snooze and dismiss together: dismiss wins, no re-ring at +5 min
    snooze = 1; dismiss = 1;
    @(negedge clk);
    clear_ctrl();
    check("both_alarm_off", alarm_signal, 0);
    set_tod(6 * 60 + 59);
    tick_next(1);
    check("both_no_rering", pending, 0);
`else
    // without snooze support the snooze input has no effect
    reset_dut();
    twelve_24 = 0;
    write_slot(1, 9, 0, 0, 1);
    set_tod(8 * 3600 + 59 * 60 + 59);
    tick_next(1);
    @(negedge clk);
    snooze = 1;
    @(negedge clk);
    snooze = 0;
    check("nosnz_still_ringing", alarm_signal, 1);
    dismiss = 1;
    @(negedge clk);
    dismiss = 0;
    check("nosnz_dismiss", alarm_signal, 0);
    check("nosnz_pending", pending, 0);
`endif

    random_phase(1, 150);
    random_phase(0, 150);
    random_phase(1, 150);
    random_phase(0, 150);

    clear_ctrl();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/alarm_scheduler.md
ALARM_SCHEDULER -- requirements
Module: alarm_scheduler

Interface
REQ-001 The block SHALL have parameter RING_SECS, default 10, ring duration in ticks (1..15).
REQ-002 The block SHALL have parameter SNOOZE_MIN, default 5, snooze offset in minutes (1..59).
REQ-003 The block SHALL have port clk, input, 1, sole clock.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port tick, input, 1, one-cycle pulse once per second, aligned with the time update.
REQ-006 The block SHALL have ports hh/mm/ss/am_pm, input, 5/6/6/1, current clock time.
REQ-007 The block SHALL have port twelve_24, input, 1, 1=12-hour mode, 0=24-hour mode.
REQ-008 The block SHALL have ports wr_en/wr_slot/wr_hh/wr_mm/wr_am_pm/wr_on, input, 1/2/5/6/1/1, slot program port.
REQ-009 The block SHALL have ports snooze and dismiss, input, 1 each, level sampled per cycle.
REQ-010 The block SHALL have ports alarm_signal/active_slot/pending/slot_on, output, 1/2/4/4: buzzer, ringing slot, match-waiting bits, slot enables.

Function
REQ-011 Four slots; each holds hh, mm, am_pm, on bit, and snooze target (hh, mm, am_pm, valid).
REQ-012 On tick with ss==0: slot i matches if on, hh and mm equal, and am_pm equal (am_pm ignored when twelve_24=0); match sets pending[i] next cycle.
REQ-013 A valid snooze target matches by the same rule; on match the target valid bit clears and pending[i] sets.
REQ-014 FSM states IDLE, RING; reset state IDLE.
REQ-015 IDLE: if pending!=0, grant the lowest-index pending slot, load active_slot, clear ring counter, go to RING; alarm_signal=1 from the following cycle.
REQ-016 RING: ring counter increments on tick; at RING_SECS ticks, clear pending[active_slot], alarm_signal=0, go to IDLE.
REQ-017 RING + snooze: clear pending[active_slot], write snooze target = current time + SNOOZE_MIN, go to IDLE, alarm_signal=0 next cycle.
REQ-018 Snooze add: minutes >=60 subtract 60 and carry hour; 24h: 23->0; 12h: 11->12 toggles am_pm, 12->1 no toggle.
REQ-019 RING + dismiss: clear pending and snooze valid of active_slot, go to IDLE; dismiss wins over snooze in the same cycle.
REQ-020 wr_en: slot fields update next cycle; pending and snooze valid of that slot clear; if that slot is ringing, go to IDLE with alarm_signal=0.
REQ-021 Matches on other slots during RING only set pending; they are serviced after return to IDLE (one idle cycle minimum).
REQ-022 Match and wr_en on the same slot in the same cycle: write wins, pending not set.

Reset
REQ-023 rst SHALL clear all slots, snooze targets, pending, and ring counter; set state IDLE, alarm_signal=0, active_slot=0, slot_on=0.
REQ-024 rst asserted mid-RING SHALL force alarm_signal=0 at the next edge regardless of other inputs.

Configuration
REQ-025 Macro ALARM_SNOOZE_EN defined: snooze behaves per REQ-013/017/018.
REQ-026 ALARM_SNOOZE_EN undefined: snooze input ignored, snooze target registers and adder absent, RING exits only by timeout, dismiss, write, or rst.

Structure
REQ-027 Shared package clock_pkg SHALL hold the FSM state typedef, NUM_ALARM_SLOTS=4, and the hour/minute/second width constants.
REQ-028 Snooze arithmetic SHALL be the sub-module snooze_time_add (combinational; time + minutes -> time, mode-aware).

Verification
REQ-029 Slot0 = 07:30 PM on (12h); clock 07:29:59 PM -> tick -> pending[0]=1, alarm_signal=1 two cycles later, falls after 10 ticks.
REQ-030 Slots 1 and 2 both = 06:00 (24h) -> active_slot=1 rings first, then slot 2 rings after timeout.
REQ-031 Slot3 = 11:58 AM, snooze during ring -> target 12:03 PM; clock reaches 12:03:00 PM -> rings again.
REQ-032 24h slot0 = 23:57, snooze -> target 00:02, match at 00:02:00.
REQ-033 During RING assert snooze and dismiss together -> IDLE, snooze valid=0, no re-ring at +5 min.
REQ-034 rst asserted during RING -> alarm_signal=0, pending=0, slot_on=0 next cycle.
